// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: SRAM geometry defaults and FSM state encoding.
// Common to the loader, the instruction SRAM and the CPU.
package prog_loader_pkg;

    localparam int DEF_ADDR   = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_LENGTH = 16;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_LOAD  = 3'd1,
        LD_CSUM  = 3'd2,
        LD_FLUSH = 3'd3,
        LD_RUN   = 3'd4,
        LD_ERR   = 3'd5
    } ld_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running mod-2^WIDTH sum over loaded bytes with clear, add and a zero test
// against the byte currently offered. Only instantiated when CHECKSUM_EN is defined.
module loader_checksum
    import prog_loader_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             add,
    input  logic [WIDTH-1:0] data,
    output logic             sum_zero
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] total;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + data;
        end
    end

    // The checksum byte is good when it brings the running sum back to zero.
    assign total    = sum + data;
    assign sum_zero = (total == '0);

endmodule

// File: rtl/prog_loader.sv
// Streams a LENGTH-word program into the instruction SRAM over valid/ready, holding the CPU in
// reset until loading completes. Optional trailing checksum byte enabled by defining CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR   = DEF_ADDR,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             mem_cs,
    output logic             mem_we,
    output logic [ADDR-1:0]  mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [ADDR-1:0] LAST = ADDR'(LENGTH - 1);
    localparam logic [ADDR-1:0] ONE  = {{(ADDR-1){1'b0}}, 1'b1};

    ld_state_t       state, state_next;
    logic [ADDR-1:0] count, count_next;
    logic            xfer;
    logic            load_xfer;
    logic            restart;

    assign in_ready  = (state == LD_LOAD) || (state == LD_CSUM);
    assign xfer      = in_valid && in_ready;
    assign load_xfer = xfer && (state == LD_LOAD);

    assign busy      = (state == LD_LOAD) || (state == LD_CSUM) || (state == LD_FLUSH);
    assign done      = (state == LD_RUN);
    assign cpu_reset = (state != LD_RUN);

`ifdef CHECKSUM_EN
    logic sum_zero;

    loader_checksum #(
        .WIDTH (WIDTH)
    ) u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (restart),
        .add      (load_xfer),
        .data     (in_data),
        .sum_zero (sum_zero)
    );

    assign error = (state == LD_ERR);
`else
    assign error = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        count_next = count;
        restart    = 1'b0;
        case (state)
            LD_IDLE: begin
                if (start) begin
                    state_next = LD_LOAD;
                    restart    = 1'b1;
                end
            end
            LD_LOAD: begin
                if (xfer) begin
                    if (count == LAST) begin
`ifdef CHECKSUM_EN
                        state_next = LD_CSUM;
`else
                        state_next = LD_FLUSH;
`endif
                    end else begin
                        count_next = count + ONE;
                    end
                end
            end
`ifdef CHECKSUM_EN
            LD_CSUM: begin
                if (xfer) begin
                    state_next = sum_zero ? LD_FLUSH : LD_ERR;
                end
            end
            LD_ERR: begin
                if (start) begin
                    state_next = LD_LOAD;
                    restart    = 1'b1;
                end
            end
`endif
            LD_FLUSH: begin
                state_next = LD_RUN;
            end
            LD_RUN: begin
                if (start) begin
                    state_next = LD_LOAD;
                    restart    = 1'b1;
                end
            end
            default: begin
                state_next = LD_IDLE;
            end
        endcase
        if (restart) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LD_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // NOTE: only the loader's own output registers are reset; the SRAM array keeps its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= load_xfer;
            mem_cs <= load_xfer || (state_next == LD_RUN);
            if (load_xfer) begin
                mem_addr  <= count;
                mem_wdata <= in_data;
            end else if (state_next == LD_RUN) begin
                mem_addr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver queues expected SRAM writes, a negedge monitor
// pops and compares them. Covers the CHECKSUM_EN build when that macro is defined.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic       mem_cs;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc++;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_val(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Monitor: every write pulse must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write (t=%0t)",
                         mem_addr, mem_wdata, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", 32'(mem_addr), 32'(e.a));
                check_val("wr_data", 32'(mem_wdata), 32'(e.d));
                check_val("wr_cycle", 32'(cyc), 32'(e.cyc));
                check_bit("wr_cs", mem_cs, 1'b1);
            end
        end
    end

    task automatic check_idle(input string tag);
        check_bit({tag, "_in_ready"}, in_ready, 1'b0);
        check_bit({tag, "_mem_cs"}, mem_cs, 1'b0);
        check_bit({tag, "_mem_we"}, mem_we, 1'b0);
        check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_val({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check_bit({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_error"}, error, 1'b0);
    endtask

    // All driver tasks start and end 1 ns after a rising edge.
    task automatic pulse_start(input string tag);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_bit({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_in_ready"}, in_ready, 1'b1);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [3:0] a, input bit wr);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        check_bit("in_ready", in_ready, 1'b1);
        if (wr) exp_q.push_back('{a: a, d: d, cyc: cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int k = 0;
        @(negedge clk);
        check_bit({tag, "_flush_done"}, done, 1'b0);
        check_bit({tag, "_flush_busy"}, busy, 1'b1);
        while (done !== 1'b1 && k < 8) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_bit({tag, "_run_done"}, done, 1'b1);
        check_val({tag, "_run_latency"}, 32'(k), 32'd1);
        check_bit({tag, "_run_cpu_reset"}, cpu_reset, 1'b0);
        check_bit({tag, "_run_cs"}, mem_cs, 1'b1);
        check_bit({tag, "_run_we"}, mem_we, 1'b0);
        check_val({tag, "_run_addr"}, 32'(mem_addr), 32'd0);
        check_bit({tag, "_run_in_ready"}, in_ready, 1'b0);
        check_bit({tag, "_run_busy"}, busy, 1'b0);
        check_bit({tag, "_run_error"}, error, 1'b0);
    endtask

    // Loads base, base+1, ... base+15 to addresses 0..15, optionally with a gap after each byte.
    task automatic load_prog(input string tag, input logic [7:0] base, input bit gaps);
        logic [7:0] sum = 8'h00;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = base + 8'(i);
            sum = sum + d;
            push_byte(d, 4'(i), 1'b1);
            if (gaps && i < 15) begin
                if (i == 7) start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check_bit({tag, "_gap_we"}, mem_we, 1'b0);
                check_val({tag, "_gap_addr"}, 32'(mem_addr), 32'(i));
                check_bit({tag, "_gap_done"}, done, 1'b0);
            end
        end
`ifdef CHECKSUM_EN
        push_byte(8'h00 - sum, 4'h0, 1'b0);
`endif
        wait_run(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        // Reset for two cycles
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("idle");
        @(posedge clk);
        #1;

        // Back-to-back bytes 00..0F
        pulse_start("start_idle");
        load_prog("b2b", 8'h00, 1'b0);

        // in_valid while in RUN must not write
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_bit("run_hold_done", done, 1'b1);
        check_bit("run_hold_we", mem_we, 1'b0);

        // Gapped bytes with a start pulse mid-load
        pulse_start("start_run1");
        load_prog("gaps", 8'h50, 1'b1);

        // Reset after 5 bytes, then a full reload
        pulse_start("start_run2");
        for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i), 4'(i), 1'b1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        pulse_start("start_after_reset");
        load_prog("reload", 8'hA0, 1'b0);

`ifdef CHECKSUM_EN
        // Good checksum: 16 x 01 + F0 == 0 mod 256
        pulse_start("start_csum_ok");
        for (int i = 0; i < 16; i++) push_byte(8'h01, 4'(i), 1'b1);
        push_byte(8'hF0, 4'h0, 1'b0);
        wait_run("csum_ok");

        // Bad checksum: 16 x 01 + F1 -> ERR, no 17th write
        pulse_start("start_csum_bad");
        for (int i = 0; i < 16; i++) push_byte(8'h01, 4'(i), 1'b1);
        push_byte(8'hF1, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_bit("err_error", error, 1'b1);
        check_bit("err_cpu_reset", cpu_reset, 1'b1);
        check_bit("err_done", done, 1'b0);
        check_bit("err_we", mem_we, 1'b0);
        check_bit("err_in_ready", in_ready, 1'b0);
        pulse_start("start_from_err");
        check_bit("err_cleared", error, 1'b0);
`else
        // Reload from RUN
        pulse_start("start_run3");
        check_bit("nocsum_error", error, 1'b0);
`endif
        load_prog("overwrite", 8'hC0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
